xor_parity_acc: RTL and testbench

XOR_PARITY_ACC -- requirements
Module: xor_parity_acc

---
 rtl/xor_parity_acc.sv | 178 +++++++++++++++++
 tb/tb_xor_parity_acc.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_parity_acc.sv
// xor_parity_acc: serial XOR parity accumulator.
// Bits on A are consumed when B=1 while a frame is in progress. After
// FRAME_LEN bits the running XOR is latched into PAR and DONE pulses for one
// cycle.
// Optional feature macro: XOR_PARITY_CHECK_EN. When defined, one more valid
// bit is taken after the data bits as the received parity bit. That bit is
// compared against F and the result is reported on ERR in the DONE cycle.
// Without the macro there is no CHECK state and ERR is tied low.
//
// Handshake: START is a request sampled only in IDLE. A is a data bit
// qualified by B; a bit is consumed on a rising edge where B=1 and the FSM
// is in ACCUM (or CHECK). With B=0 the frame stalls indefinitely. There is
// no backpressure towards the source.
//
// o_dbg_state exposes the FSM state encoding:
//   0 = IDLE, 1 = ACCUM, 2 = CHECK, 3 = DONE_ST.
module xor_parity_acc #(
  parameter int FRAME_LEN = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       A,
  input  logic       B,
  output logic       F,
  output logic       PAR,
  output logic       DONE,
  output logic       BUSY,
  output logic [7:0] CNT,
  output logic       ERR,
  output logic [1:0] o_dbg_state
);

  // Index of the last data bit: the bit consumed while CNT equals it
  // completes the data portion of the frame.
  localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

`ifdef XOR_PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    CHECK   = 2'd2,
    DONE_ST = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DONE_ST = 2'd3
  } state_t;
`endif

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_f;
  logic       r_par;
  logic [7:0] r_cnt;
  logic       w_start_frame;
  logic       w_consume;
  logic       w_enter_done;
  logic       w_par_load;

  // Next-state logic plus the per-cycle strobes the datapath uses.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_frame = 1'b0;
    w_consume     = 1'b0;
    w_enter_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (START) begin
          w_start_frame = 1'b1;
          w_state_nxt   = ACCUM;
        end
      end
      ACCUM: begin
        if (B) begin
          w_consume = 1'b1;
          if (r_cnt == LAST_IDX) begin
`ifdef XOR_PARITY_CHECK_EN
            w_state_nxt = CHECK;
`else
            w_state_nxt  = DONE_ST;
            w_enter_done = 1'b1;
`endif
          end
        end
      end
`ifdef XOR_PARITY_CHECK_EN
      CHECK: begin
        // The received parity bit is not a data bit. It moves the FSM on,
        // but it does not touch F or CNT.
        if (B) begin
          w_state_nxt  = DONE_ST;
          w_enter_done = 1'b1;
        end
      end
`endif
      DONE_ST: begin
        // START is deliberately ignored here. A new frame can only begin
        // from IDLE on the following cycle.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Value PAR captures on entry to DONE_ST. Without the check stage, this
  // includes the last data bit consumed on that same edge.
`ifdef XOR_PARITY_CHECK_EN
  assign w_par_load = r_f;
`else
  assign w_par_load = r_f ^ A;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Running XOR and bit counter. Both clear only at a frame start, so they
  // hold their final values through DONE_ST and the following IDLE cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_f   <= 1'b0;
      r_cnt <= 8'd0;
    end else if (w_start_frame) begin
      r_f   <= 1'b0;
      r_cnt <= 8'd0;
    end else if (w_consume) begin
      r_f   <= r_f ^ A;
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Final parity, updated only when a frame actually completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par <= 1'b0;
    end else if (w_enter_done) begin
      r_par <= w_par_load;
    end
  end

`ifdef XOR_PARITY_CHECK_EN
  logic r_err;

  // Mismatch flag: set for the DONE cycle only, cleared on every other edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_enter_done) begin
      r_err <= r_f ^ A;
    end else begin
      r_err <= 1'b0;
    end
  end

  assign ERR  = r_err;
  assign BUSY = (r_state == ACCUM) || (r_state == CHECK);
`else
  assign ERR  = 1'b0;
  assign BUSY = (r_state == ACCUM);
`endif

  assign F           = r_f;
  assign PAR         = r_par;
  assign CNT         = r_cnt;
  assign DONE        = (r_state == DONE_ST);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_xor_parity_acc.sv
// Directed testbench for xor_parity_acc (FRAME_LEN = 8).
// The same bench also builds with XOR_PARITY_CHECK_EN defined. In that build,
// frames carry a trailing parity bit, and the check tests replace the
// no-check tests.
module tb_xor_parity_acc;

  logic       CLK;
  logic       RST;
  logic       START;
  logic       A;
  logic       B;
  logic       F;
  logic       PAR;
  logic       DONE;
  logic       BUSY;
  logic [7:0] CNT;
  logic       ERR;
  logic [1:0] dbg_state;

  int checks;
  int failures;

  xor_parity_acc #(.FRAME_LEN(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .A          (A),
    .B          (B),
    .F          (F),
    .PAR        (PAR),
    .DONE       (DONE),
    .BUSY       (BUSY),
    .CNT        (CNT),
    .ERR        (ERR),
    .o_dbg_state(dbg_state)
  );

  // Clock generation.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // In the check build, confirm the FSM is waiting in CHECK, then supply the
  // received parity bit. In the default build there is nothing to send.
  task automatic send_parity(input logic p);
`ifdef XOR_PARITY_CHECK_EN
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL check_state done=%b busy=%b expected done=0 busy=1", DONE, BUSY);
    end
    A = p;
    B = 1'b1;
    tick();
    B = 1'b0;
    A = 1'b0;
`else
    A = p;
`endif
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    START = 1'b0;
    A     = 1'b0;
    B     = 1'b0;
    #3;
    checks++;
    if ({F, PAR, DONE, BUSY, ERR, CNT} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got f=%b par=%b done=%b busy=%b err=%b cnt=%0d expected all 0",
               F, PAR, DONE, BUSY, ERR, CNT);
    end
    tick();
    tick();
    RST = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b expected 0 0", BUSY, DONE);
    end
  endtask

  // Bits 1,0,1,1,0,0,1,0 with B=1 every cycle. PAR must be 0.
  // DONE rises on the 8th edge after the START edge, so it occupies the 9th
  // clock period counted from that edge.
  task automatic test_basic();
    logic [0:7] bits;
    logic       exp_f;
    bits  = 8'b10110010;
    exp_f = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++;
    if (BUSY !== 1'b1 || CNT !== 8'd0 || F !== 1'b0) begin
      failures++;
      $display("FAIL basic_start busy=%b cnt=%0d f=%b expected 1 0 0", BUSY, CNT, F);
    end
    for (int i = 0; i < 8; i++) begin
      A = bits[i];
      B = 1'b1;
      tick();
      exp_f = exp_f ^ bits[i];
      checks++;
      if (F !== exp_f || CNT !== 8'(i + 1)) begin
        failures++;
        $display("FAIL basic_bit%0d f=%b cnt=%0d expected f=%b cnt=%0d", i, F, CNT, exp_f, i + 1);
      end
      if (i < 7) begin
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b1) begin
          failures++;
          $display("FAIL basic_busy%0d done=%b busy=%b expected 0 1", i, DONE, BUSY);
        end
      end
    end
    B = 1'b0;
    A = 1'b0;
    send_parity(1'b0);
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || PAR !== 1'b0 || CNT !== 8'd8 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL basic_done done=%b busy=%b par=%b cnt=%0d err=%b expected 1 0 0 8 0",
               DONE, BUSY, PAR, CNT, ERR);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || PAR !== 1'b0 || CNT !== 8'd8 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL basic_after done=%b par=%b cnt=%0d busy=%b expected 0 0 8 0", DONE, PAR, CNT, BUSY);
    end
  endtask

  // Same frame with a 3-cycle stall after bit 4. While stalled, F=1 and
  // CNT=4, and DONE arrives exactly 3 cycles later than in test_basic.
  task automatic test_stall();
    logic [0:7] bits;
    logic       exp_f;
    int         edges;
    bits  = 8'b10110010;
    exp_f = 1'b0;
    edges = 0;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      A = bits[i];
      B = 1'b1;
      tick();
      edges++;
      exp_f = exp_f ^ bits[i];
      if (i == 3) begin
        for (int s = 0; s < 3; s++) begin
          B = 1'b0;
          A = s[0];
          tick();
          edges++;
          checks++;
          if (F !== 1'b1 || CNT !== 8'd4 || DONE !== 1'b0 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold%0d f=%b cnt=%0d done=%b busy=%b expected 1 4 0 1",
                     s, F, CNT, DONE, BUSY);
          end
        end
      end
    end
    B = 1'b0;
    A = 1'b0;
    send_parity(1'b0);
    checks++;
    if (DONE !== 1'b1 || PAR !== 1'b0 || CNT !== 8'd8 || edges != 11) begin
      failures++;
      $display("FAIL stall_done done=%b par=%b cnt=%0d edges=%0d expected 1 0 8 11", DONE, PAR, CNT, edges);
    end
    tick();
  endtask

  // Bits 1,1,1,0,0,0,0,0 give PAR=1. A START pulse during ACCUM is ignored.
  task automatic test_par_one();
    logic [0:7] bits;
    logic       exp_f;
    bits  = 8'b11100000;
    exp_f = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      A     = bits[i];
      B     = 1'b1;
      START = (i == 2 || i == 5);
      tick();
      START = 1'b0;
      exp_f = exp_f ^ bits[i];
      checks++;
      if (F !== exp_f || CNT !== 8'(i + 1)) begin
        failures++;
        $display("FAIL parone_bit%0d f=%b cnt=%0d expected f=%b cnt=%0d", i, F, CNT, exp_f, i + 1);
      end
    end
    B = 1'b0;
    A = 1'b0;
    send_parity(1'b1);
    checks++;
    if (DONE !== 1'b1 || PAR !== 1'b1 || CNT !== 8'd8 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL parone_done done=%b par=%b cnt=%0d err=%b expected 1 1 8 0", DONE, PAR, CNT, ERR);
    end
    tick();
    checks++;
    if (PAR !== 1'b1 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL parone_hold par=%b done=%b expected 1 0", PAR, DONE);
    end
  endtask

  // Assert RST between edges after 5 bits. Outputs must clear before the next
  // edge, no DONE may follow, and a fresh START is needed afterwards.
  task automatic test_reset_mid();
    logic [0:4] bits;
    bits  = 5'b10110;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      A = bits[i];
      B = 1'b1;
      tick();
    end
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if ({F, PAR, DONE, BUSY, ERR, CNT} !== 13'd0) begin
      failures++;
      $display("FAIL rstmid_async f=%b par=%b done=%b busy=%b err=%b cnt=%0d expected all 0",
               F, PAR, DONE, BUSY, ERR, CNT);
    end
    tick();
    RST = 1'b0;
    checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_nodone done=%b busy=%b expected 0 0", DONE, BUSY);
    end
    A = 1'b1;
    B = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || CNT !== 8'd0 || F !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_idle%0d busy=%b done=%b cnt=%0d f=%b expected 0 0 0 0", i, BUSY, DONE, CNT, F);
      end
    end
    A = 1'b0;
    B = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      A = 1'b0;
      B = 1'b1;
      tick();
    end
    B = 1'b0;
    send_parity(1'b0);
    checks++;
    if (DONE !== 1'b1 || PAR !== 1'b0 || CNT !== 8'd8 || F !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_zero done=%b par=%b cnt=%0d f=%b expected 1 0 8 0", DONE, PAR, CNT, F);
    end
    tick();
  endtask

`ifdef XOR_PARITY_CHECK_EN
  // Bits 1,0,1,1,0,0,1,0 give F=0. A parity bit of 1 must flag ERR, a parity
  // bit of 0 must not. The parity bit is excluded from F and CNT.
  task automatic test_check();
    logic [0:7] bits;
    logic       pbit;
    logic       exp_err;
    bits = 8'b10110010;
    for (int r = 0; r < 2; r++) begin
      pbit    = (r == 0);
      exp_err = (r == 0);
      START   = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 8; i++) begin
        A = bits[i];
        B = 1'b1;
        tick();
      end
      B = 1'b0;
      A = 1'b1;
      tick();
      checks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0 || CNT !== 8'd8 || F !== 1'b0) begin
        failures++;
        $display("FAIL check_stall%0d busy=%b done=%b cnt=%0d f=%b expected 1 0 8 0", r, BUSY, DONE, CNT, F);
      end
      A = pbit;
      B = 1'b1;
      tick();
      B = 1'b0;
      checks++;
      if (DONE !== 1'b1 || ERR !== exp_err || PAR !== 1'b0 || F !== 1'b0 || CNT !== 8'd8) begin
        failures++;
        $display("FAIL check_err%0d done=%b err=%b par=%b f=%b cnt=%0d expected 1 %b 0 0 8",
                 r, DONE, ERR, PAR, F, CNT, exp_err);
      end
      tick();
      checks++;
      if (ERR !== 1'b0 || DONE !== 1'b0) begin
        failures++;
        $display("FAIL check_errclr%0d err=%b done=%b expected 0 0", r, ERR, DONE);
      end
    end
  endtask
`else
  // Without the check stage, DONE follows the 8th bit directly and ERR stays
  // 0. A valid bit presented in the DONE cycle is not consumed.
  task automatic test_no_check();
    logic [0:7] bits;
    bits  = 8'b10110010;
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      A = bits[i];
      B = 1'b1;
      tick();
      checks++;
      if (ERR !== 1'b0) begin
        failures++;
        $display("FAIL nocheck_err%0d err=%b expected 0", i, ERR);
      end
    end
    checks++;
    if (DONE !== 1'b1 || ERR !== 1'b0 || PAR !== 1'b0) begin
      failures++;
      $display("FAIL nocheck_done done=%b err=%b par=%b expected 1 0 0", DONE, ERR, PAR);
    end
    A = 1'b1;
    B = 1'b1;
    tick();
    B = 1'b0;
    A = 1'b0;
    checks++;
    if (F !== 1'b0 || CNT !== 8'd8 || BUSY !== 1'b0 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL nocheck_extra f=%b cnt=%0d busy=%b err=%b expected 0 8 0 0", F, CNT, BUSY, ERR);
    end
  endtask
`endif

  // START held high through two frames. The DONE_ST cycle must not restart;
  // the following IDLE cycle must.
  task automatic test_back_to_back();
    logic [0:7] bits0;
    logic [0:7] bits1;
    bits0 = 8'b10110010;
    bits1 = 8'b11100000;
    START = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      A = bits0[i];
      B = 1'b1;
      tick();
    end
    B = 1'b0;
    send_parity(1'b0);
    checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || PAR !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done1 done=%b busy=%b par=%b expected 1 0 0", DONE, BUSY, PAR);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || CNT !== 8'd8) begin
      failures++;
      $display("FAIL b2b_idle busy=%b done=%b cnt=%0d expected 0 0 8", BUSY, DONE, CNT);
    end
    tick();
    checks++;
    if (BUSY !== 1'b1 || CNT !== 8'd0 || F !== 1'b0) begin
      failures++;
      $display("FAIL b2b_restart busy=%b cnt=%0d f=%b expected 1 0 0", BUSY, CNT, F);
    end
    for (int i = 0; i < 8; i++) begin
      A = bits1[i];
      B = 1'b1;
      tick();
    end
    B = 1'b0;
    send_parity(1'b1);
    checks++;
    if (DONE !== 1'b1 || PAR !== 1'b1 || CNT !== 8'd8) begin
      failures++;
      $display("FAIL b2b_done2 done=%b par=%b cnt=%0d expected 1 1 8", DONE, PAR, CNT);
    end
    START = 1'b0;
    tick();
    tick();
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Test sequence and final report.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_stall();
    test_par_one();
    test_reset_mid();
`ifdef XOR_PARITY_CHECK_EN
    test_check();
`else
    test_no_check();
`endif
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
